// File: rtl/count_seq_monitor_pkg.sv
// Shared types and default parameters for the count sequence monitor.
package count_seq_mon_pkg;

   // Monitor lock state.
   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StAcquire = 2'b01,
      StLocked  = 2'b10
   } state_e;

   localparam int unsigned DefWidth     = 4;
   localparam int unsigned DefLockCount = 2;
   localparam int unsigned DefErrCntW   = 8;
   localparam int unsigned DefWrapCntW  = 8;

endpackage

// File: rtl/count_seq_monitor_if.sv
// Sample/status bundle between the consumer and the count sequence monitor.
interface count_seq_monitor_if #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned ERR_CNT_W  = 8,
   parameter int unsigned WRAP_CNT_W = 8
) ();

   logic                  clr;
   logic                  en;
   logic [WIDTH-1:0]      count_in;
   logic                  locked;
   logic                  err_pulse;
   logic                  wrap_pulse;
   logic [ERR_CNT_W-1:0]  err_count;
   logic [WRAP_CNT_W-1:0] wrap_count;
   logic [WIDTH-1:0]      expected;

   // Consumer side: drives samples and control, observes status.
   modport master (
      output clr, en, count_in,
      input  locked, err_pulse, wrap_pulse, err_count, wrap_count, expected
   );

   // Monitor side.
   modport slave (
      input  clr, en, count_in,
      output locked, err_pulse, wrap_pulse, err_count, wrap_count, expected
   );

endinterface

// File: rtl/count_seq_monitor_sat.sv
// Saturating event counter: counts inc requests, sticks at all-ones.
module sat_event_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   // Next count: clear wins, otherwise increment unless already saturated.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/count_seq_monitor.sv
// Checks that a counter stream advances by +1 mod 2^WIDTH, locks onto it,
// and reports sequence errors and rollovers as pulses and saturating totals.
module count_seq_monitor
   import count_seq_mon_pkg::*;
#(
   parameter int unsigned WIDTH      = DefWidth,
   parameter int unsigned LOCK_COUNT = DefLockCount,
   parameter int unsigned ERR_CNT_W  = DefErrCntW,
   parameter int unsigned WRAP_CNT_W = DefWrapCntW
) (
   input logic              clk,
   input logic              rst,
   count_seq_monitor_if.slave mon
);

   localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [3:0]       match_cnt_q, match_cnt_d;
   logic             locked_q, locked_d;
   logic             err_pulse_q, err_pulse_d;
   logic             wrap_pulse_q, wrap_pulse_d;
   logic             err_ev, wrap_ev;
   logic [WIDTH-1:0] prev_inc;
   logic             is_inc;

   assign prev_inc = prev_q + WIDTH'(1);
   assign is_inc   = (mon.count_in == prev_inc);

   // Next-state and event decode; clear beats the sample qualifier.
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      exp_d       = exp_q;
      match_cnt_d = match_cnt_q;
      err_ev      = 1'b0;
      wrap_ev     = 1'b0;
      if (mon.clr) begin
         state_d     = StIdle;
         prev_d      = '0;
         exp_d       = WIDTH'(1);
         match_cnt_d = '0;
      end else if (mon.en) begin
         prev_d = mon.count_in;
         exp_d  = mon.count_in + WIDTH'(1);
         unique case (state_q)
            StIdle: begin
               state_d     = StAcquire;
               match_cnt_d = '0;
            end
            StAcquire: begin
               if (is_inc) begin
                  if (match_cnt_q + 4'd1 == LockCnt) begin
                     state_d     = StLocked;
                     match_cnt_d = '0;
                  end else begin
                     match_cnt_d = match_cnt_q + 4'd1;
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end
            StLocked: begin
               if (is_inc) begin
                  wrap_ev = (prev_q == {WIDTH{1'b1}});
               end else begin
                  err_ev      = 1'b1;
                  state_d     = StAcquire;
                  match_cnt_d = '0;
               end
            end
            default: begin
               state_d     = StIdle;
               match_cnt_d = '0;
            end
         endcase
      end
      err_pulse_d  = err_ev;
      wrap_pulse_d = wrap_ev;
      locked_d     = (state_d == StLocked);
   end

   // FSM state and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         prev_q       <= '0;
         exp_q        <= WIDTH'(1);
         match_cnt_q  <= '0;
         locked_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         wrap_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         exp_q        <= exp_d;
         match_cnt_q  <= match_cnt_d;
         locked_q     <= locked_d;
         err_pulse_q  <= err_pulse_d;
         wrap_pulse_q <= wrap_pulse_d;
      end
   end

   sat_event_counter #(
      .W(ERR_CNT_W)
   ) u_err_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (mon.clr),
      .inc  (err_ev),
      .count(mon.err_count)
   );

   sat_event_counter #(
      .W(WRAP_CNT_W)
   ) u_wrap_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (mon.clr),
      .inc  (wrap_ev),
      .count(mon.wrap_count)
   );

   assign mon.locked     = locked_q;
   assign mon.err_pulse  = err_pulse_q;
   assign mon.wrap_pulse = wrap_pulse_q;
   assign mon.expected   = exp_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Bench for count_seq_monitor: directed stream, behavioural model, per-cycle compare.
module tb_count_seq_monitor;

   localparam int W  = 4;
   localparam int LK = 2;
   localparam int EW = 2;
   localparam int WW = 8;
   localparam int MOD = 1 << W;
   localparam int EMAX = (1 << EW) - 1;
   localparam int WMAX = (1 << WW) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   count_seq_monitor_if #(.WIDTH(W), .ERR_CNT_W(EW), .WRAP_CNT_W(WW)) bus ();

   count_seq_monitor #(
      .WIDTH     (W),
      .LOCK_COUNT(LK),
      .ERR_CNT_W (EW),
      .WRAP_CNT_W(WW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mon(bus)
   );

   int n_vec = 0;
   int n_bad = 0;
   int n_errp = 0;
   int n_wrapp = 0;
   bit chk = 1'b0;

   // Model: mode 0 idle, 1 acquiring, 2 locked.
   int m_mode = 0, m_run = 0, m_prev = 0, m_exp = 1, m_errc = 0, m_wrapc = 0;
   bit m_errp = 0, m_wrapp = 0;
   int ci;
   bit inc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
      end
   endtask

   task m_reset();
      m_mode = 0; m_run = 0; m_prev = 0; m_exp = 1;
      m_errc = 0; m_wrapc = 0; m_errp = 0; m_wrapp = 0;
   endtask

   always @(negedge rst) m_reset();

   always @(posedge clk) begin
      if (!rst || bus.clr) begin
         m_reset();
      end else if (bus.en) begin
         ci = int'(bus.count_in);
         inc = (ci == (m_prev + 1) % MOD);
         m_errp = 0;
         m_wrapp = 0;
         if (m_mode == 0) begin
            m_mode = 1; m_run = 0;
         end else if (m_mode == 1) begin
            if (inc) begin
               m_run++;
               if (m_run == LK) begin m_mode = 2; m_run = 0; end
            end else m_run = 0;
         end else begin
            if (inc) begin
               if (m_prev == MOD - 1) begin
                  m_wrapp = 1;
                  if (m_wrapc < WMAX) m_wrapc++;
               end
            end else begin
               m_errp = 1;
               if (m_errc < EMAX) m_errc++;
               m_mode = 1; m_run = 0;
            end
         end
         m_prev = ci;
         m_exp = (ci + 1) % MOD;
      end else begin
         m_errp = 0;
         m_wrapp = 0;
      end
   end

   // Compare every output against the model each cycle, away from the edge.
   always @(negedge clk) begin
      if (chk) begin
         check("locked", 32'(bus.locked), 32'(m_mode == 2));
         check("err_pulse", 32'(bus.err_pulse), 32'(m_errp));
         check("wrap_pulse", 32'(bus.wrap_pulse), 32'(m_wrapp));
         check("err_count", 32'(bus.err_count), m_errc);
         check("wrap_count", 32'(bus.wrap_count), m_wrapc);
         check("expected", 32'(bus.expected), m_exp);
         if (bus.err_pulse === 1'b1) n_errp++;
         if (bus.wrap_pulse === 1'b1) n_wrapp++;
      end
   end

   // Apply one sample; returns just after the capturing edge.
   task automatic feed_en(input bit e, input int v);
      @(negedge clk);
      #1;
      bus.en = e;
      bus.count_in = 4'(v % MOD);
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int v);
      feed_en(1'b1, v);
   endtask

   int p;

   initial begin
      rst = 1'b0;
      bus.clr = 1'b0;
      bus.en = 1'b0;
      bus.count_in = 4'd9;
      @(posedge clk);
      #1;
      chk = 1'b1;
      check("rst_locked", 32'(bus.locked), 0);
      check("rst_errc", 32'(bus.err_count), 0);
      check("rst_wrapc", 32'(bus.wrap_count), 0);
      check("rst_exp", 32'(bus.expected), 1);
      check("rst_pulses", 32'({bus.err_pulse, bus.wrap_pulse}), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Lock onto 0,1,2,...
      feed(0);
      feed(1);
      check("lock_early", 32'(bus.locked), 0);
      feed(2);
      check("lock_after2", 32'(bus.locked), 1);
      check("lock_exp", 32'(bus.expected), 3);
      for (int v = 3; v <= 12; v++) feed(v);
      check("lock_noerr", 32'(bus.err_count), 0);

      // Rollover.
      n_wrapp = 0;
      feed(13); feed(14); feed(15);
      feed(0);
      check("wrap_pulse_at0", 32'(bus.wrap_pulse), 1);
      check("wrap_exp", 32'(bus.expected), 1);
      feed(1);
      check("wrap_once", n_wrapp, 1);
      check("wrap_cnt1", 32'(bus.wrap_count), 1);
      check("wrap_noerr", 32'(bus.err_count), 0);
      check("wrap_locked", 32'(bus.locked), 1);

      // Error and relock.
      feed(2); feed(3); feed(4);
      feed(7);
      check("err_pulse7", 32'(bus.err_pulse), 1);
      check("err_unlock", 32'(bus.locked), 0);
      check("err_cnt1", 32'(bus.err_count), 1);
      feed(8);
      check("relock_early", 32'(bus.locked), 0);
      feed(9);
      check("relock", 32'(bus.locked), 1);

      // Walk to 5, mask, then continue with 6.
      for (int v = 10; v <= 21; v++) feed(v);
      check("wrap_cnt2", 32'(bus.wrap_count), 2);
      repeat (5) feed_en(1'b0, 5);
      feed(6);
      check("mask_noerr", 32'(bus.err_pulse), 0);
      check("mask_errc", 32'(bus.err_count), 1);
      check("mask_locked", 32'(bus.locked), 1);

      // Synchronous clear with en high.
      bus.clr = 1'b1;
      feed(7);
      bus.clr = 1'b0;
      check("clr_errc", 32'(bus.err_count), 0);
      check("clr_wrapc", 32'(bus.wrap_count), 0);
      check("clr_locked", 32'(bus.locked), 0);
      check("clr_exp", 32'(bus.expected), 1);

      // Saturation: five lock/break cycles with a repeated value.
      n_errp = 0;
      feed(0);
      p = 0;
      repeat (5) begin
         feed(p + 1);
         feed(p + 2);
         check("sat_locked", 32'(bus.locked), 1);
         feed(p + 2);
         p = p + 2;
      end
      feed(p + 1);
      check("sat_pulses", n_errp, 5);
      check("sat_errc", 32'(bus.err_count), 3);
      feed(p + 2);
      check("sat_relock", 32'(bus.locked), 1);

      // Asynchronous reset in mid-cycle while locked.
      #2;
      rst = 1'b0;
      #1;
      check("arst_locked", 32'(bus.locked), 0);
      check("arst_errc", 32'(bus.err_count), 0);
      check("arst_exp", 32'(bus.expected), 1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      feed(3);
      feed(4);
      check("post_rst_acq", 32'(bus.locked), 0);
      feed(5);
      check("post_rst_lock", 32'(bus.locked), 1);

      @(negedge clk);
      #1;
      chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Downstream checker for the 4-bit binary up counter; consumes its `count` bus every clock.
- Verifies the stream advances by +1 modulo 2^WIDTH, locks onto the sequence, and reports sequence errors and rollovers.
- Provides registered pulses and saturating statistics for status/debug logic.
- `en` lets the consumer mask cycles where the counter is held in reset.

Parameters:
- WIDTH, 4, width of monitored count bus.
- LOCK_COUNT, 2, consecutive correct increments required to enter LOCKED (legal range 1..15).
- ERR_CNT_W, 8, width of saturating error counter.
- WRAP_CNT_W, 8, width of saturating rollover counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- clr  in  1  synchronous clear of state and statistics, active-high.
- en  in  1  sample qualifier; count_in is ignored when 0.
- count_in  in  WIDTH  count value from upstream counter.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per sequence error.
- wrap_pulse  out  1  one-cycle pulse per legal rollover (max -> 0).
- err_count  out  ERR_CNT_W  saturating total of errors.
- wrap_count  out  WRAP_CNT_W  saturating total of rollovers.
- expected  out  WIDTH  prev+1 mod 2^WIDTH (next expected value).

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, prev=0, match_cnt=0;
  - locked=0, err_pulse=0, wrap_pulse=0, err_count=0, wrap_count=0, expected=1.
- Release is synchronous to clk in the integrating design.
- Priority: rst > clr > en.
  - clr=1: same values as reset on the next edge, regardless of en.
  - en=0: no state or statistic change; pulses deassert.
- "inc" means count_in == prev+1 mod 2^WIDTH. Width arithmetic drops the carry.
- prev <= count_in on every qualified edge (en=1, clr=0), in every state.
- IDLE:
  - First qualified sample -> ACQUIRE, match_cnt=0.
  - No error is possible in IDLE.
- ACQUIRE:
  - inc: match_cnt++; if match_cnt+1 == LOCK_COUNT -> LOCKED, match_cnt=0.
  - Not inc: match_cnt=0, stay in ACQUIRE, no err_pulse.
  - Rollovers are not counted in ACQUIRE.
- LOCKED:
  - inc with prev == 2^WIDTH-1 (count_in=0): wrap_pulse=1 next cycle; wrap_count++ saturating.
  - inc otherwise: no event.
  - Not inc, including a repeated value: err_pulse=1 next cycle; err_count++ saturating; -> ACQUIRE with match_cnt=0; locked falls on the same edge.
- Latency: pulses and the locked change appear in the cycle after the edge that captured the deciding sample.
- Saturation: the counters stick at all-ones; an event at saturation still produces its pulse.
- expected <= count_in+1 on qualified edges.
- Reset mid-LOCKED: everything returns to IDLE immediately (asynchronously); no pulse is emitted.

Decomposition:
- Package count_seq_mon_pkg:
  - state typedef: IDLE=2'b00, ACQUIRE=2'b01, LOCKED=2'b10;
  - default parameter constants.
- Sub-module sat_event_counter (parameter W; ports clk, rst, clr, inc, count), instantiated twice for err_count and wrap_count.

Test Plan:
- Reset: hold rst=0 for 2 cycles with count_in=9 -> locked=0, err_count=0, wrap_count=0, expected=1, no pulses.
- Lock: en=1, feed 0,1,2,3 (defaults) -> locked=1 in the cycle after the edge sampling 2; no err_pulse.
- Rollover: while locked, feed 13,14,15,0,1 -> exactly one wrap_pulse (after 0 is sampled), wrap_count=1, err_count=0, locked stays 1.
- Error/relock: while locked, feed 3,4,7,8,9 -> one err_pulse after 7, err_count=1, locked=0 after 7, locked=1 again after 9.
- Masking/clear: en=0 for 5 cycles with count_in held at 5, then en=1 with 6 -> no err_pulse; then clr=1 with en=1 -> all statistics 0, locked=0.
- Saturation/async reset: ERR_CNT_W=2, force 5 lock/break cycles -> err_count=3, five err_pulses; assert rst=0 mid-cycle while locked -> locked=0 before the next edge.
